// File: rtl/stage_fetch_queued.sv
// stage_fetch_queued: decoupled multi-lane fetch stage with branch-prediction truncation and a bundle queue
module stage_fetch_queued #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4,
  parameter int GHR_BITS = 8,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic [WIDTH*32-1:0]   icache_read_addr_o,
  input  logic [WIDTH-1:0]      icache_valid_i,
  input  logic [WIDTH*32-1:0]   icache_inst_i,
  output logic                  bp_req_valid_o,
  output logic [31:0]           bp_req_pc_o,
  output logic                  bp_req_used_o,
  input  logic                  bp_resp_taken_i,
  input  logic [31:0]           bp_resp_target_i,
  input  logic [GHR_BITS-1:0]   bp_resp_ghr_i,
  input  logic                  ib_stall_i,
  output logic                  ib_bundle_valid_o,
  output logic [WIDTH-1:0]      ib_lane_valid_o,
  output logic [WIDTH*32-1:0]   ib_inst_o,
  output logic [WIDTH*32-1:0]   ib_pc_o,
  output logic [WIDTH-1:0]      ib_pred_taken_o,
  output logic [31:0]           ib_pred_target_o,
  output logic [GHR_BITS-1:0]   ib_ghr_o,
  input  logic                  ex_redirect_valid_i,
  input  logic [31:0]           ex_redirect_pc_i,
  input  logic                  fetch_enable_i,
  output logic                  fetch_stall_o,
  output logic [31:0]           pc_dbg_o
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int KW = $clog2(WIDTH + 1);
  localparam int BW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  logic [31:0] pc, next_pc;
  logic [WIDTH-1:0] acc, keep, pt;
  logic [KW-1:0] k;
  logic [BW-1:0] b;
  logic run, has_br, taken, push, pop, head_valid, full;
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [WIDTH*32-1:0] q_inst [DEPTH];
  logic [31:0] q_pc [DEPTH];
  logic [31:0] q_tgt [DEPTH];
  logic [WIDTH-1:0] q_lv [DEPTH];
  logic [WIDTH-1:0] q_pt [DEPTH];
  logic [GHR_BITS-1:0] q_ghr [DEPTH];
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  // accepted prefix, first conditional branch and truncation behind a taken prediction
  always_comb begin
    acc = '0;
    keep = '0;
    pt = '0;
    k = '0;
    b = '0;
    run = 1'b1;
    has_br = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      run = run & icache_valid_i[i];
      acc[i] = run;
      k = k + KW'(run);
    end
    for (int i = WIDTH - 1; i >= 0; i--)
      if (acc[i] && icache_inst_i[i*32 +: 7] == 7'b1100011) begin
        has_br = 1'b1;
        b = BW'(i);
      end
    taken = has_br & bp_resp_taken_i;
    for (int i = 0; i < WIDTH; i++) begin
      keep[i] = acc[i] & !(taken && BW'(i) > b);
      pt[i] = taken && BW'(i) == b;
    end
    next_pc = taken ? bp_resp_target_i : pc + (32'(k) << 2);
  end
  assign full = count == CW'(DEPTH);
  assign head_valid = count != '0 && !ex_redirect_valid_i;
  assign pop = head_valid & !ib_stall_i;
  assign push = fetch_enable_i & !reset & !ex_redirect_valid_i & |acc & (!full | pop);
  assign fetch_stall_o = fetch_enable_i & !ex_redirect_valid_i & (~|acc | (full & !pop));
  assign bp_req_valid_o = has_br & !reset;
  assign bp_req_pc_o = pc + (32'(b) << 2);
  assign bp_req_used_o = push & has_br;
  assign pc_dbg_o = pc;
  assign ib_bundle_valid_o = head_valid;
  assign ib_lane_valid_o = head_valid ? q_lv[head] : '0;
  assign ib_pred_taken_o = head_valid ? q_pt[head] : '0;
  assign ib_inst_o = q_inst[head];
  assign ib_pred_target_o = q_tgt[head];
  assign ib_ghr_o = q_ghr[head];
  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    assign icache_read_addr_o[g*32 +: 32] = pc + 32'(4 * g);
    assign ib_pc_o[g*32 +: 32] = q_pc[head] + 32'(4 * g);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      pc <= RESET_PC;
      head <= '0;
      tail <= '0;
      count <= '0;
    end else if (ex_redirect_valid_i) begin
      pc <= ex_redirect_pc_i;
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (push) pc <= next_pc;
      if (push) tail <= inc(tail);
      if (pop) head <= inc(head);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clock)
    if (push) begin
      q_inst[tail] <= icache_inst_i;
      q_pc[tail] <= pc;
      q_tgt[tail] <= bp_resp_target_i;
      q_lv[tail] <= keep;
      q_pt[tail] <= pt;
      q_ghr[tail] <= bp_resp_ghr_i;
    end
endmodule

// File: tb/tb_stage_fetch_queued.sv
// tb_stage_fetch_queued: directed self-checking bench for the queued fetch stage
module tb_stage_fetch_queued;
  localparam logic [31:0] ADDI = 32'h13;
  localparam logic [31:0] BEQ = 32'h63;
  logic clock = 1'b0;
  logic reset;
  logic [95:0] icache_read_addr_o;
  logic [2:0] icache_valid_i;
  logic [95:0] icache_inst_i;
  logic bp_req_valid_o;
  logic [31:0] bp_req_pc_o;
  logic bp_req_used_o;
  logic bp_resp_taken_i;
  logic [31:0] bp_resp_target_i;
  logic [7:0] bp_resp_ghr_i;
  logic ib_stall_i;
  logic ib_bundle_valid_o;
  logic [2:0] ib_lane_valid_o;
  logic [95:0] ib_inst_o;
  logic [95:0] ib_pc_o;
  logic [2:0] ib_pred_taken_o;
  logic [31:0] ib_pred_target_o;
  logic [7:0] ib_ghr_o;
  logic ex_redirect_valid_i;
  logic [31:0] ex_redirect_pc_i;
  logic fetch_enable_i;
  logic fetch_stall_o;
  logic [31:0] pc_dbg_o;
  int checks = 0;
  int errors = 0;

  stage_fetch_queued #(.WIDTH(3), .DEPTH(4), .GHR_BITS(8), .RESET_PC(32'h0)) dut (
    .clock(clock), .reset(reset),
    .icache_read_addr_o(icache_read_addr_o), .icache_valid_i(icache_valid_i), .icache_inst_i(icache_inst_i),
    .bp_req_valid_o(bp_req_valid_o), .bp_req_pc_o(bp_req_pc_o), .bp_req_used_o(bp_req_used_o),
    .bp_resp_taken_i(bp_resp_taken_i), .bp_resp_target_i(bp_resp_target_i), .bp_resp_ghr_i(bp_resp_ghr_i),
    .ib_stall_i(ib_stall_i), .ib_bundle_valid_o(ib_bundle_valid_o), .ib_lane_valid_o(ib_lane_valid_o),
    .ib_inst_o(ib_inst_o), .ib_pc_o(ib_pc_o), .ib_pred_taken_o(ib_pred_taken_o),
    .ib_pred_target_o(ib_pred_target_o), .ib_ghr_o(ib_ghr_o),
    .ex_redirect_valid_i(ex_redirect_valid_i), .ex_redirect_pc_i(ex_redirect_pc_i),
    .fetch_enable_i(fetch_enable_i), .fetch_stall_o(fetch_stall_o), .pc_dbg_o(pc_dbg_o)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    fetch_enable_i = 1'b1;
    icache_valid_i = 3'b111;
    icache_inst_i = {ADDI, ADDI, BEQ};
    bp_resp_taken_i = 1'b0;
    bp_resp_target_i = 32'h0;
    bp_resp_ghr_i = 8'h0;
    ib_stall_i = 1'b0;
    ex_redirect_valid_i = 1'b0;
    ex_redirect_pc_i = 32'h0;
    tick();
    checks++; if (bp_req_valid_o !== 1'b0) begin errors++; $display("FAIL rst_bp_valid got %b exp 0", bp_req_valid_o); end
    checks++; if (bp_req_used_o !== 1'b0) begin errors++; $display("FAIL rst_bp_used got %b exp 0", bp_req_used_o); end
    tick();
    reset = 1'b0;
    icache_inst_i = {ADDI, ADDI, ADDI};
    #1;
    checks++; if (pc_dbg_o !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp 0", pc_dbg_o); end
    checks++; if (icache_read_addr_o !== {32'h8, 32'h4, 32'h0}) begin errors++; $display("FAIL rst_addr got %h exp %h", icache_read_addr_o, {32'h8, 32'h4, 32'h0}); end
    checks++; if (ib_bundle_valid_o !== 1'b0 || ib_lane_valid_o !== 3'b000) begin errors++; $display("FAIL rst_ib got %b/%b exp 0/000", ib_bundle_valid_o, ib_lane_valid_o); end
    checks++; if (bp_req_used_o !== 1'b0 || fetch_stall_o !== 1'b0) begin errors++; $display("FAIL rst_used_stall got %b/%b exp 0/0", bp_req_used_o, fetch_stall_o); end
  endtask

  task automatic test_basic;
    tick();
    checks++; if (pc_dbg_o !== 32'hC) begin errors++; $display("FAIL basic_pc got %h exp c", pc_dbg_o); end
    checks++; if (ib_bundle_valid_o !== 1'b1 || ib_lane_valid_o !== 3'b111) begin errors++; $display("FAIL basic_valid got %b/%b exp 1/111", ib_bundle_valid_o, ib_lane_valid_o); end
    checks++; if (ib_pc_o !== {32'h8, 32'h4, 32'h0}) begin errors++; $display("FAIL basic_ibpc got %h exp %h", ib_pc_o, {32'h8, 32'h4, 32'h0}); end
    checks++; if (ib_inst_o !== {ADDI, ADDI, ADDI}) begin errors++; $display("FAIL basic_inst got %h exp %h", ib_inst_o, {ADDI, ADDI, ADDI}); end
  endtask

  task automatic test_branch;
    icache_inst_i = {ADDI, BEQ, ADDI};
    bp_resp_taken_i = 1'b1;
    bp_resp_target_i = 32'h100;
    bp_resp_ghr_i = 8'hA5;
    #1;
    checks++; if (bp_req_valid_o !== 1'b1 || bp_req_pc_o !== 32'h10) begin errors++; $display("FAIL br_req got %b/%h exp 1/10", bp_req_valid_o, bp_req_pc_o); end
    checks++; if (bp_req_used_o !== 1'b1) begin errors++; $display("FAIL br_used got %b exp 1", bp_req_used_o); end
    tick();
    checks++; if (pc_dbg_o !== 32'h100) begin errors++; $display("FAIL br_taken_pc got %h exp 100", pc_dbg_o); end
    checks++; if (ib_lane_valid_o !== 3'b011 || ib_pred_taken_o !== 3'b010) begin errors++; $display("FAIL br_taken_lanes got %b/%b exp 011/010", ib_lane_valid_o, ib_pred_taken_o); end
    checks++; if (ib_pred_target_o !== 32'h100 || ib_ghr_o !== 8'hA5 || ib_pc_o[31:0] !== 32'hC) begin errors++; $display("FAIL br_taken_fields got %h/%h/%h exp 100/a5/c", ib_pred_target_o, ib_ghr_o, ib_pc_o[31:0]); end
    bp_resp_taken_i = 1'b0;
    #1;
    checks++; if (bp_req_pc_o !== 32'h104) begin errors++; $display("FAIL br_nt_reqpc got %h exp 104", bp_req_pc_o); end
    tick();
    checks++; if (pc_dbg_o !== 32'h10C) begin errors++; $display("FAIL br_nt_pc got %h exp 10c", pc_dbg_o); end
    checks++; if (ib_lane_valid_o !== 3'b111 || ib_pred_taken_o !== 3'b000) begin errors++; $display("FAIL br_nt_lanes got %b/%b exp 111/000", ib_lane_valid_o, ib_pred_taken_o); end
  endtask

  task automatic test_partial;
    icache_inst_i = {ADDI, ADDI, ADDI};
    icache_valid_i = 3'b011;
    tick();
    checks++; if (pc_dbg_o !== 32'h114) begin errors++; $display("FAIL part_pc got %h exp 114", pc_dbg_o); end
    checks++; if (ib_lane_valid_o !== 3'b011 || ib_pc_o[31:0] !== 32'h10C) begin errors++; $display("FAIL part_lanes got %b/%h exp 011/10c", ib_lane_valid_o, ib_pc_o[31:0]); end
    icache_valid_i = 3'b110;
    #1;
    checks++; if (fetch_stall_o !== 1'b1 || bp_req_used_o !== 1'b0) begin errors++; $display("FAIL gap_stall got %b/%b exp 1/0", fetch_stall_o, bp_req_used_o); end
    tick();
    checks++; if (pc_dbg_o !== 32'h114) begin errors++; $display("FAIL gap_pc got %h exp 114", pc_dbg_o); end
    checks++; if (ib_bundle_valid_o !== 1'b0) begin errors++; $display("FAIL gap_noenq got %b exp 0", ib_bundle_valid_o); end
  endtask

  task automatic test_stall_full;
    icache_valid_i = 3'b111;
    ib_stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (fetch_stall_o !== 1'b0) begin errors++; $display("FAIL fill_stall%0d got %b exp 0", i, fetch_stall_o); end
      tick();
    end
    tick();
    checks++; if (fetch_stall_o !== 1'b1 || pc_dbg_o !== 32'h144) begin errors++; $display("FAIL full_stall got %b/%h exp 1/144", fetch_stall_o, pc_dbg_o); end
    tick();
    checks++; if (pc_dbg_o !== 32'h144 || ib_pc_o[31:0] !== 32'h114) begin errors++; $display("FAIL full_hold got %h/%h exp 144/114", pc_dbg_o, ib_pc_o[31:0]); end
    ib_stall_i = 1'b0;
    #1;
    checks++; if (fetch_stall_o !== 1'b0 || bp_req_used_o !== 1'b0) begin errors++; $display("FAIL pushpop_stall got %b exp 0", fetch_stall_o); end
    tick();
    ib_stall_i = 1'b1;
    #1;
    checks++; if (pc_dbg_o !== 32'h150 || ib_pc_o[31:0] !== 32'h120) begin errors++; $display("FAIL pushpop_adv got %h/%h exp 150/120", pc_dbg_o, ib_pc_o[31:0]); end
    checks++; if (fetch_stall_o !== 1'b1) begin errors++; $display("FAIL pushpop_count got %b exp 1", fetch_stall_o); end
  endtask

  task automatic test_redirect;
    fetch_enable_i = 1'b0;
    ib_stall_i = 1'b0;
    #1;
    checks++; if (fetch_stall_o !== 1'b0) begin errors++; $display("FAIL dis_stall got %b exp 0", fetch_stall_o); end
    tick();
    checks++; if (pc_dbg_o !== 32'h150 || ib_pc_o[31:0] !== 32'h12C) begin errors++; $display("FAIL dis_drain got %h/%h exp 150/12c", pc_dbg_o, ib_pc_o[31:0]); end
    fetch_enable_i = 1'b1;
    icache_inst_i = {ADDI, ADDI, BEQ};
    bp_resp_taken_i = 1'b1;
    bp_resp_target_i = 32'h200;
    ex_redirect_valid_i = 1'b1;
    ex_redirect_pc_i = 32'h1234;
    #1;
    checks++; if (ib_bundle_valid_o !== 1'b0 || ib_lane_valid_o !== 3'b000 || bp_req_used_o !== 1'b0) begin errors++; $display("FAIL redir_now got %b/%b/%b exp 0/000/0", ib_bundle_valid_o, ib_lane_valid_o, bp_req_used_o); end
    tick();
    ex_redirect_valid_i = 1'b0;
    bp_resp_taken_i = 1'b0;
    icache_inst_i = {ADDI, ADDI, ADDI};
    #1;
    checks++; if (icache_read_addr_o[31:0] !== 32'h1234 || ib_bundle_valid_o !== 1'b0) begin errors++; $display("FAIL redir_next got %h/%b exp 1234/0", icache_read_addr_o[31:0], ib_bundle_valid_o); end
    tick();
    checks++; if (ib_bundle_valid_o !== 1'b1 || ib_pc_o[31:0] !== 32'h1234 || pc_dbg_o !== 32'h1240) begin errors++; $display("FAIL redir_first got %b/%h/%h exp 1/1234/1240", ib_bundle_valid_o, ib_pc_o[31:0], pc_dbg_o); end
  endtask

  task automatic test_wrap;
    ex_redirect_valid_i = 1'b1;
    ex_redirect_pc_i = 32'hFFFF_FFF8;
    tick();
    ex_redirect_valid_i = 1'b0;
    #1;
    checks++; if (icache_read_addr_o[95:64] !== 32'h0) begin errors++; $display("FAIL wrap_addr got %h exp 0", icache_read_addr_o[95:64]); end
    tick();
    checks++; if (pc_dbg_o !== 32'h4) begin errors++; $display("FAIL wrap_pc got %h exp 4", pc_dbg_o); end
  endtask

  task automatic test_reset_priority;
    ib_stall_i = 1'b1;
    repeat (5) tick();
    checks++; if (fetch_stall_o !== 1'b1) begin errors++; $display("FAIL prio_full got %b exp 1", fetch_stall_o); end
    reset = 1'b1;
    ex_redirect_valid_i = 1'b1;
    ex_redirect_pc_i = 32'h5555;
    tick();
    reset = 1'b0;
    ex_redirect_valid_i = 1'b0;
    #1;
    checks++; if (pc_dbg_o !== 32'h0 || ib_bundle_valid_o !== 1'b0) begin errors++; $display("FAIL prio_state got %h/%b exp 0/0", pc_dbg_o, ib_bundle_valid_o); end
    repeat (3) tick();
    checks++; if (fetch_stall_o !== 1'b0 || ib_pc_o[31:0] !== 32'h0) begin errors++; $display("FAIL prio_count got %b/%h exp 0/0", fetch_stall_o, ib_pc_o[31:0]); end
    tick();
    checks++; if (fetch_stall_o !== 1'b1 || pc_dbg_o !== 32'h30) begin errors++; $display("FAIL prio_refill got %b/%h exp 1/30", fetch_stall_o, pc_dbg_o); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_branch();
    test_partial();
    test_stall_full();
    test_redirect();
    test_wrap();
    test_reset_priority();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/stage_fetch_queued.md
# stage_fetch_queued

Parametrised, decoupled fetch stage. Each cycle it issues WIDTH sequential iCache lane addresses and accepts the valid prefix of returned instructions. It consults the branch predictor on the first conditional branch in that prefix and pushes the resulting bundle into a DEPTH-entry fetch queue that drains to the instruction buffer. It sits between the iCache/branch predictor and the instruction buffer; an execute-stage redirect flushes the queue and restarts fetch.

## Interface
- WIDTH, 3: lanes per bundle (≥1).
- DEPTH, 4: fetch-queue entries in bundles (≥2, need not be a power of two).
- GHR_BITS, 8: predictor history snapshot width.
- RESET_PC, 32'h0: PC loaded on reset.
- clock  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- icache_read_addr_o  out  WIDTH×32  lane i address = pc + 4i.
- icache_valid_i  in  WIDTH  lane i data valid this cycle.
- icache_inst_i  in  WIDTH×32  lane i instruction.
- bp_req_valid_o  out  1  an accepted lane holds a conditional branch (opcode 7'b1100011).
- bp_req_pc_o  out  32  PC of the first such lane.
- bp_req_used_o  out  1  prediction consumed (bundle enqueued).
- bp_resp_taken_i  in  1  prediction, same cycle.
- bp_resp_target_i  in  32  predicted target.
- bp_resp_ghr_i  in  GHR_BITS  history snapshot.
- ib_stall_i  in  1  instruction buffer cannot accept.
- ib_bundle_valid_o  out  1  queue head presented.
- ib_lane_valid_o  out  WIDTH  per-lane valid of head.
- ib_inst_o / ib_pc_o  out  WIDTH×32 each  head instructions / PCs.
- ib_pred_taken_o  out  WIDTH  set only on the predicted-taken branch lane.
- ib_pred_target_o  out  32  target of that branch.
- ib_ghr_o  out  GHR_BITS  snapshot stored with the bundle.
- ex_redirect_valid_i  in  1  flush and redirect.
- ex_redirect_pc_i  in  32  new PC.
- fetch_enable_i  in  1  allow fetching.
- fetch_stall_o  out  1  fetch wanted but blocked.
- pc_dbg_o  out  32  current pc register.

## Operation
- Accepted lanes: longest prefix 0..k-1 with icache_valid_i set (k=0..WIDTH).
- First branch b = lowest accepted lane whose opcode is 1100011. bp_req_valid_o=1 and bp_req_pc_o=pc+4b if b exists; otherwise valid=0 and pc is don't-care.
- Truncation: if b exists and bp_resp_taken_i=1, lanes above b are dropped, next_pc=bp_resp_target_i, and that bundle's lane b is marked pred_taken. Otherwise next_pc=pc+4k (32-bit wrap).
- Enqueue condition: fetch_enable_i & !reset & !ex_redirect_valid_i & k>0 & (count<DEPTH | pop). On enqueue, pc<=next_pc and the bundle is stored with inst, pc, lane valids, pred fields and ghr.
- bp_req_used_o = enqueue & b exists.
- fetch_stall_o = fetch_enable_i & !ex_redirect_valid_i & (k==0 | (count==DEPTH & !pop)). The pc holds while stalled.
- Dequeue: ib_bundle_valid_o = (count>0) & !ex_redirect_valid_i. pop = ib_bundle_valid_o & !ib_stall_i. The head pointer advances on pop. When ib_bundle_valid_o=0, ib_lane_valid_o=0 and ib_pred_taken_o=0.
- Pointers wrap DEPTH-1→0. count is $clog2(DEPTH+1) bits. Push and pop in the same cycle leave count unchanged, including when full.
- Redirect: pc<=ex_redirect_pc_i, head=tail=count=0, no enqueue. Redirect beats enqueue and pop.
- Reset beats redirect: pc<=RESET_PC and the queue is emptied.
- fetch_enable_i=0: no enqueue, pc holds, bp_req_used_o=0, fetch_stall_o=0. Dequeue continues normally.

## Timing
- Outputs after reset: pc_dbg_o=RESET_PC, icache_read_addr_o[i]=RESET_PC+4i, ib_bundle_valid_o=0, ib_lane_valid_o=0, bp_req_used_o=0, fetch_stall_o=0. While reset is asserted, bp_req_valid_o and bp_req_used_o are forced to 0.
- iCache and predictor responses are combinational in the cycle the address is presented.
- Enqueue-to-IB latency is 1 cycle. A bundle fetched at edge t is visible on ib_* after edge t; there is no bypass.
- Redirect asserted in cycle t: ib_bundle_valid_o=0 in cycle t; icache_read_addr_o[0]=ex_redirect_pc_i after edge t. The first new bundle reaches ib_* after edge t+1.
- Maximum throughput is one bundle per cycle in steady state.

## Test plan
- Reset, enable, all lanes ADDI 32'h13 valid: addresses 0/4/8. After the edge, pc=0xC, ib_bundle_valid_o=1, ib_pc_o=0/4/8, ib_lane_valid_o=3'b111.
- BEQ 32'h63 in lane 1, taken, target 0x100: bp_req_pc_o=pc+4, bp_req_used_o=1. Enqueued lane valids 3'b011, ib_pred_taken_o=3'b010, next pc=0x100. With not-taken: lanes 3'b111, pc+12.
- icache_valid_i=3'b011: 2 lanes enqueued, pc+8. icache_valid_i=3'b110: fetch_stall_o=1, pc holds, nothing enqueued.
- ib_stall_i=1 with continuous fetch: after 4 bundles fetch_stall_o=1 and pc frozen. Drop ib_stall_i one cycle: simultaneous pop and push, count stays 4, fetch_stall_o=0 that cycle.
- Redirect to 0x1234 with 3 bundles queued and BEQ in lane 0: in that cycle ib_bundle_valid_o=0 and bp_req_used_o=0. Next cycle addr[0]=0x1234 and the queue is empty. The following cycle ib_pc_o[0]=0x1234.
- Reset asserted with a full queue and redirect pending simultaneously: next cycle pc=RESET_PC, ib_bundle_valid_o=0, count=0.
